// File: rtl/popcount_serial_acc.sv
// Serial popcount: accepts a WIDTH-bit word, counts its set bits one nibble per clock,
// reports the per-word count and keeps a saturating running total across words.
module popcount_serial_acc #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 16,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InValid,
  input  logic [WIDTH-1:0]     InData,
  output logic                 Ready,
  input  logic                 Clear,
  output logic                 OutValid,
  output logic [CW-1:0]        Count,
  output logic [ACC_WIDTH-1:0] Total,
  output logic                 Saturated
);

  // state | meaning
  // IDLE  | Ready high, waiting for InValid
  // COUNT | one nibble of the latched word summed per clock, N clocks
  // DONE  | OutValid high for one cycle; Total updated on exit

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("popcount_serial_acc: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [IW-1:0]    nib_idx;
  logic [CW-1:0]    partial;
  logic [CW-1:0]    partial_next;
  logic [ACC_WIDTH:0] total_sum;

  // Same 4-in/3-out ones-count used by the combinational encoder this replaces
  function automatic logic [2:0] ones4(input logic [3:0] n);
    ones4 = {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  assign partial_next = partial + CW'(ones4(shift_q[3:0]));
  assign total_sum    = {1'b0, Total} + (ACC_WIDTH + 1)'(Count);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      Ready     <= 1'b1;
      OutValid  <= 1'b0;
      Count     <= '0;
      Total     <= '0;
      Saturated <= 1'b0;
      shift_q   <= '0;
      nib_idx   <= '0;
      partial   <= '0;
    end else begin
      OutValid <= 1'b0;
      case (state)
        IDLE: begin
          if (InValid) begin
            shift_q <= InData;
            partial <= '0;
            nib_idx <= '0;
            Ready   <= 1'b0;
            state   <= COUNT;
          end
        end
        COUNT: begin
          shift_q <= shift_q >> 4;
          partial <= partial_next;
          nib_idx <= nib_idx + 1'b1;
          if (nib_idx == IW'(N - 1)) begin
            Count    <= partial_next;
            OutValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // Sum is one bit wider than Total so the carry flags saturation
          if (total_sum[ACC_WIDTH]) begin
            Total     <= '1;
            Saturated <= 1'b1;
          end else begin
            Total <= total_sum[ACC_WIDTH-1:0];
          end
          Ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          Ready <= 1'b1;
          state <= IDLE;
        end
      endcase
      // Clear overrides any Total update made on the same edge
      if (Clear) begin
        Total     <= '0;
        Saturated <= 1'b0;
      end
    end
  end

endmodule

// File: doc/popcount_serial_acc.md
Name: popcount_serial_acc

Overview:
- Parametrised, sequential successor to the team's 4-input ones-count encoder.
- Accepts a WIDTH-bit word through a valid/ready handshake and counts its set bits serially, one 4-bit nibble per clock, using the same 4-in/3-out ones-count function internally.
- Reports the per-word count and keeps a saturating running total across words, with a clear input.
- Sits between a data source (switch bank or shift register) and display/status logic.

Parameters:
- WIDTH, 16: input word width; must be a multiple of 4 and at least 4.
- ACC_WIDTH, 16: width of the running total register.
- CW, $clog2(WIDTH+1): derived, not overridable; width of the per-word count.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  source presents a word on InData.
- InData  input  WIDTH  word to count.
- Ready  output  1  block can accept a word; high only in state IDLE.
- Clear  input  1  synchronous clear of Total and Saturated.
- OutValid  output  1  one-cycle pulse; Count holds a new result.
- Count  output  CW  number of ones in the last completed word.
- Total  output  ACC_WIDTH  saturating sum of Count over completed words since the last Reset or Clear.
- Saturated  output  1  sticky; set when a sum would exceed 2^ACC_WIDTH-1.

Behaviour:
- Interface: one clock (Clock); Reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values:
  - state is IDLE, so Ready=1.
  - OutValid=0, Count=0, Total=0, Saturated=0.
  - The internal shift register, nibble index and partial sum are all 0.
- FSM states: IDLE, COUNT, DONE.
  - IDLE: Ready=1. On an edge with InValid=1, latch InData into the shift register, clear the partial sum and nibble index, and go to COUNT. With InValid=0, stay in IDLE.
  - COUNT: Ready=0; InData and InValid are ignored. Each edge adds the ones-count (0..4) of the low nibble to the partial sum, shifts the register right by 4 and increments the index. After N=WIDTH/4 COUNT edges, load Count with the partial sum and go to DONE.
  - DONE: OutValid=1 for exactly this one cycle. On the exiting edge, update Total and go to IDLE unconditionally; a word offered during DONE is not accepted.
- Latency and throughput:
  - Accepting edge at cycle 0 gives OutValid high during cycle N+1, with Count valid from that cycle.
  - Count holds its value until the next DONE.
  - Maximum throughput is one word per N+2 cycles.
- Arithmetic:
  - The partial sum is CW bits wide and cannot overflow, since the maximum is WIDTH.
  - On the DONE exit edge, Total = min(Total + Count, 2^ACC_WIDTH-1), computed at ACC_WIDTH+1 bits.
  - If the unclamped sum exceeds 2^ACC_WIDTH-1, set Saturated. Saturated stays set until Clear or Reset.
- Clear:
  - Clear in any state zeroes Total and Saturated on that edge.
  - If Clear coincides with the DONE exit edge, Clear wins: Total=0 and the finishing word is not added. Count and OutValid are unaffected.
  - Clear does not disturb the FSM or a word in progress.
- Reset mid-operation (in COUNT or DONE) aborts the word: no OutValid is produced, all outputs take their reset values, and the block returns to IDLE.
- Zero word: runs the full N COUNT cycles and produces Count=0 with OutValid asserted; Total is unchanged.

Test Plan:
(WIDTH=16, ACC_WIDTH=6, so N=4 and CW=5.)
1. Reset then accept InData=16'h0000 at cycle 0.
   - Ready is low during cycles 1-5.
   - OutValid is high in cycle 5 only, with Count=0 and Total=0.
   - Ready returns high in cycle 6.
2. Words 16'h8421 (one bit per nibble), then 16'hFFFF, then 16'h0F0F, each offered in the cycle Ready returns high.
   - Count=4, 16, 8 in turn.
   - Total=4, 20, 28.
   - Each OutValid comes exactly 5 cycles after its accepting edge.
3. Hold InValid=1 with changing InData throughout.
   - Only words present on IDLE edges are accepted, one every 6 cycles.
   - Data changes during COUNT do not alter Count.
4. Saturation: four 16'hFFFF words after Reset.
   - Total runs 16, 32, 48, then 63 (clamped from 64), and Saturated=1 after the fourth word.
   - A fifth word leaves Total=63.
   - Clear then gives Total=0 and Saturated=0.
5. Clear asserted on the DONE exit edge of a 16'h00FF word.
   - Count=8 and OutValid=1.
   - Total=0 afterwards.
6. Reset asserted in the second COUNT cycle of a 16'hFFFF word.
   - No OutValid is produced and Count=0.
   - Ready=1 on the next cycle.
   - A following 16'h0003 word yields Count=2 and Total=2.
